// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the fetch/data memory port arbiter: FSM encodings,
// decoder MEM_len codes and the active-low write strobe value.
package mem_port_arbiter_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUS_I = 2'd1;
    localparam logic [1:0] BUS_D = 2'd2;
    localparam logic [1:0] MISAL = 2'd3;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    // Same polarity as the decoder's MEM_wen: low means store.
    localparam logic WEN_WRITE = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } bus_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side ports and memory-bus signals of the arbiter in one bundle.
// master is the arbiter's view; slave is the core/memory environment's view.
interface mem_port_arbiter_if;

    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_ack_o;
    logic [31:0] instr_data_o;

    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_wen_i;
    logic [1:0]  data_len_i;
    logic [31:0] data_wdata_i;
    logic        data_ack_o;
    logic [31:0] data_rdata_o;
    logic        data_misaligned_o;

    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_wen_o;
    logic [3:0]  bus_wmask_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_addr_i, data_wen_i, data_len_i, data_wdata_i,
        input  bus_ack_i, bus_rdata_i,
        output instr_ack_o, instr_data_o,
        output data_ack_o, data_rdata_o, data_misaligned_o,
        output bus_req_o, bus_addr_o, bus_wen_o, bus_wmask_o, bus_wdata_o
    );

    modport slave (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_addr_i, data_wen_i, data_len_i, data_wdata_i,
        output bus_ack_i, bus_rdata_i,
        input  instr_ack_o, instr_data_o,
        input  data_ack_o, data_rdata_o, data_misaligned_o,
        input  bus_req_o, bus_addr_o, bus_wen_o, bus_wmask_o, bus_wdata_o
    );

endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane mask, write-data replication and misalignment detection for a
// data-port access, derived from the decoder's MEM_len / MEM_wen encoding.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  len,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_aligned,
    output logic        misaligned
);

    // Replicating the store data into every lane lets the mask alone pick the lane.
    always_comb begin
        wmask         = 4'b1111;
        wdata_aligned = wdata;
        misaligned    = 1'b0;
        case (len)
            LEN_B: begin
                wdata_aligned = {4{wdata[7:0]}};
                if (wen == WEN_WRITE) wmask = 4'b0001 << addr_lo;
            end
            LEN_H: begin
                misaligned    = addr_lo[0];
                wdata_aligned = {2{wdata[15:0]}};
                if (wen == WEN_WRITE) wmask = 4'b0011 << addr_lo;
            end
            default: misaligned = (addr_lo != 2'b00);
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and the MEM
// stage data port; data has priority, bounded by a starvation counter.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_BURST_MAX = 4,
    parameter int CNT_W          = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    mem_port_arbiter_if.master    ports
);

    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(DATA_BURST_MAX);

    logic [1:0]       state;
    logic [CNT_W-1:0] burst_cnt;
    bus_cmd_t         cmd;
    logic             instr_ack;
    logic             data_ack;
    logic             misaligned;
    logic [31:0]      instr_data;
    logic [31:0]      data_rdata;

    logic [3:0]       lane_wmask;
    logic [31:0]      lane_wdata;
    logic             lane_misal;
    logic             instr_elig;
    logic             data_elig;
    logic             pick_d;
    logic             pick_i;

    mem_lane_align u_lane_align (
        .addr_lo       (ports.data_addr_i[1:0]),
        .len           (ports.data_len_i),
        .wen           (ports.data_wen_i),
        .wdata         (ports.data_wdata_i),
        .wmask         (lane_wmask),
        .wdata_aligned (lane_wdata),
        .misaligned    (lane_misal)
    );

    // A request still high during its own ack cycle is the stale one just served.
    assign instr_elig = ports.instr_req_i & ~instr_ack;
    assign data_elig  = ports.data_req_i & ~data_ack;
    assign pick_d     = data_elig & (~instr_elig | (burst_cnt != BURST_LIMIT));
    assign pick_i     = instr_elig & ~pick_d;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            cmd        <= '{addr: 32'h0, wen: 1'b1, wmask: 4'hF, wdata: 32'h0};
            instr_ack  <= 1'b0;
            data_ack   <= 1'b0;
            misaligned <= 1'b0;
            instr_data <= 32'h0;
            data_rdata <= 32'h0;
        end else begin
            instr_ack  <= 1'b0;
            data_ack   <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state <= lane_misal ? MISAL : BUS_D;
                        if (!lane_misal) begin
                            cmd <= '{addr:  ports.data_addr_i & 32'hFFFF_FFFC,
                                     wen:   ports.data_wen_i,
                                     wmask: lane_wmask,
                                     wdata: lane_wdata};
                        end
                    end else if (pick_i) begin
                        state     <= BUS_I;
                        cmd.addr  <= ports.instr_addr_i & 32'hFFFF_FFFC;
                        cmd.wen   <= 1'b1;
                        cmd.wmask <= 4'hF;
                    end
                    if (pick_i || !instr_elig) begin
                        burst_cnt <= '0;
                    end else if (pick_d && burst_cnt != BURST_LIMIT) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                BUS_I: begin
                    if (ports.bus_ack_i) begin
                        instr_data <= ports.bus_rdata_i;
                        instr_ack  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                BUS_D: begin
                    if (ports.bus_ack_i) begin
                        data_rdata <= ports.bus_rdata_i;
                        data_ack   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    data_ack   <= 1'b1;
                    misaligned <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign ports.bus_req_o         = (state == BUS_I) || (state == BUS_D);
    assign ports.bus_addr_o        = cmd.addr;
    assign ports.bus_wen_o         = cmd.wen;
    assign ports.bus_wmask_o       = cmd.wmask;
    assign ports.bus_wdata_o       = cmd.wdata;
    assign ports.instr_ack_o       = instr_ack;
    assign ports.instr_data_o      = instr_data;
    assign ports.data_ack_o        = data_ack;
    assign ports.data_rdata_o      = data_rdata;
    assign ports.data_misaligned_o = misaligned;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic compared cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int BURST = 4;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;

    mem_port_arbiter_if bus_if();

    mem_port_arbiter #(.DATA_BURST_MAX(BURST), .CNT_W(3)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ports   (bus_if)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    bit hold_both = 1'b0;

    // Model: transaction in flight ("I" fetch, "D" data, "M" misaligned, 0 none).
    byte         m_txn;
    bit          m_iack, m_dack, m_dmis;
    logic [31:0] m_idata, m_ddata, m_addr, m_wdata;
    logic        m_wen;
    logic [3:0]  m_mask;
    int          m_run;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic bit spec_misaligned(input logic [31:0] a, input logic [1:0] len);
        if (len == 2'd0) return 1'b0;
        if (len == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [3:0] spec_mask(input logic [31:0] a, input logic [1:0] len, input logic wen);
        int lane;
        lane = int'(a % 4);
        if (wen) return 4'hF;
        if (len == 2'd0) return 4'(1 << lane);
        if (len == 2'd1) return 4'(3 << lane);
        return 4'hF;
    endfunction

    function automatic logic [31:0] spec_wdata(input logic [31:0] d, input logic [1:0] len);
        if (len == 2'd0) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (len == 2'd1) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    task automatic model_reset();
        m_txn   = 8'd0;
        m_iack  = 1'b0;
        m_dack  = 1'b0;
        m_dmis  = 1'b0;
        m_idata = 32'h0;
        m_ddata = 32'h0;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        m_wen   = 1'b1;
        m_mask  = 4'hF;
        m_run   = 0;
    endtask

    // Advance the model across one rising edge using this cycle's inputs.
    task automatic model_step();
        bit ie, de, take_data, n_iack, n_dack, n_dmis;
        n_iack = 1'b0;
        n_dack = 1'b0;
        n_dmis = 1'b0;
        ie = bus_if.instr_req_i && !m_iack;
        de = bus_if.data_req_i && !m_dack;
        if (m_txn == "I" || m_txn == "D") begin
            if (bus_if.bus_ack_i) begin
                if (m_txn == "I") begin
                    m_idata = bus_if.bus_rdata_i;
                    n_iack  = 1'b1;
                end else begin
                    m_ddata = bus_if.bus_rdata_i;
                    n_dack  = 1'b1;
                end
                m_txn = 8'd0;
            end
        end else if (m_txn == "M") begin
            n_dack = 1'b1;
            n_dmis = 1'b1;
            m_txn  = 8'd0;
        end else begin
            take_data = de && (!ie || m_run < BURST);
            if (take_data) begin
                m_run = ie ? ((m_run < BURST) ? m_run + 1 : BURST) : 0;
                if (spec_misaligned(bus_if.data_addr_i, bus_if.data_len_i)) begin
                    m_txn = "M";
                end else begin
                    m_txn   = "D";
                    m_addr  = bus_if.data_addr_i & 32'hFFFF_FFFC;
                    m_wen   = bus_if.data_wen_i;
                    m_mask  = spec_mask(bus_if.data_addr_i, bus_if.data_len_i, bus_if.data_wen_i);
                    m_wdata = spec_wdata(bus_if.data_wdata_i, bus_if.data_len_i);
                end
            end else if (ie) begin
                m_txn  = "I";
                m_run  = 0;
                m_addr = bus_if.instr_addr_i & 32'hFFFF_FFFC;
                m_wen  = 1'b1;
                m_mask = 4'hF;
            end else begin
                m_run = 0;
            end
        end
        m_iack = n_iack;
        m_dack = n_dack;
        m_dmis = n_dmis;
    endtask

    task automatic compare_cycle();
        bit on_bus;
        on_bus = (m_txn == "I") || (m_txn == "D");
        checkOutput("bus_req", 32'(bus_if.bus_req_o), 32'(on_bus));
        checkOutput("instr_ack", 32'(bus_if.instr_ack_o), 32'(m_iack));
        checkOutput("data_ack", 32'(bus_if.data_ack_o), 32'(m_dack));
        checkOutput("instr_data", bus_if.instr_data_o, m_idata);
        checkOutput("data_rdata", bus_if.data_rdata_o, m_ddata);
        if (on_bus) begin
            checkOutput("bus_addr", bus_if.bus_addr_o, m_addr);
            checkOutput("bus_wen", 32'(bus_if.bus_wen_o), 32'(m_wen));
            checkOutput("bus_wmask", 32'(bus_if.bus_wmask_o), 32'(m_mask));
            if (!m_wen) checkOutput("bus_wdata", bus_if.bus_wdata_o, m_wdata);
        end
        if (m_dack) checkOutput("data_misaligned", 32'(bus_if.data_misaligned_o), 32'(m_dmis));
    endtask

    task automatic tick();
        @(negedge clk_i);
        compare_cycle();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    // Requests are only changed when idle or in their own ack cycle.
    task automatic applyStimulus();
        if (!bus_if.instr_req_i || m_iack) begin
            bus_if.instr_req_i  = hold_both || ($urandom_range(0, 2) != 0);
            bus_if.instr_addr_i = $urandom & 32'hFFFF_FFFC;
        end
        if (!bus_if.data_req_i || m_dack) begin
            bus_if.data_req_i   = hold_both || ($urandom_range(0, 2) != 0);
            bus_if.data_addr_i  = $urandom;
            if (hold_both || $urandom_range(0, 1) == 0) bus_if.data_addr_i[1:0] = 2'b00;
            bus_if.data_len_i   = 2'($urandom_range(0, 3));
            bus_if.data_wen_i   = 1'($urandom_range(0, 1));
            bus_if.data_wdata_i = $urandom;
        end
        bus_if.bus_ack_i   = ($urandom_range(0, 4) < 3);
        bus_if.bus_rdata_i = $urandom;
    endtask

    initial begin
        bus_if.instr_req_i  = 1'b0;
        bus_if.instr_addr_i = 32'h0;
        bus_if.data_req_i   = 1'b0;
        bus_if.data_addr_i  = 32'h0;
        bus_if.data_wen_i   = 1'b1;
        bus_if.data_len_i   = 2'd2;
        bus_if.data_wdata_i = 32'h0;
        bus_if.bus_ack_i    = 1'b0;
        bus_if.bus_rdata_i  = 32'h0;
        model_reset();

        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_bus_req", 32'(bus_if.bus_req_o), 32'h0);
        checkOutput("rst_bus_wen", 32'(bus_if.bus_wen_o), 32'h1);
        checkOutput("rst_bus_wmask", 32'(bus_if.bus_wmask_o), 32'hF);
        checkOutput("rst_bus_addr", bus_if.bus_addr_o, 32'h0);
        checkOutput("rst_bus_wdata", bus_if.bus_wdata_o, 32'h0);
        checkOutput("rst_instr_ack", 32'(bus_if.instr_ack_o), 32'h0);
        checkOutput("rst_data_ack", 32'(bus_if.data_ack_o), 32'h0);
        checkOutput("rst_misaligned", 32'(bus_if.data_misaligned_o), 32'h0);
        reset_i = 1'b1;

        // Zero-wait fetch
        bus_if.instr_req_i  = 1'b1;
        bus_if.instr_addr_i = 32'h100;
        bus_if.bus_ack_i    = 1'b1;
        bus_if.bus_rdata_i  = 32'h0000_0013;
        tick();
        checkOutput("zw_bus_req", 32'(bus_if.bus_req_o), 32'h1);
        checkOutput("zw_bus_addr", bus_if.bus_addr_o, 32'h100);
        tick();
        checkOutput("zw_instr_ack", 32'(bus_if.instr_ack_o), 32'h1);
        checkOutput("zw_instr_data", bus_if.instr_data_o, 32'h0000_0013);
        bus_if.instr_req_i = 1'b0;
        tick();
        checkOutput("zw_single_txn", 32'(bus_if.bus_req_o), 32'h0);

        // Byte store into lane 3
        bus_if.data_req_i   = 1'b1;
        bus_if.data_wen_i   = 1'b0;
        bus_if.data_len_i   = 2'd0;
        bus_if.data_addr_i  = 32'h203;
        bus_if.data_wdata_i = 32'h0000_00AB;
        tick();
        checkOutput("bs_addr", bus_if.bus_addr_o, 32'h200);
        checkOutput("bs_wmask", 32'(bus_if.bus_wmask_o), 32'h8);
        checkOutput("bs_wdata", bus_if.bus_wdata_o, 32'hABAB_ABAB);
        checkOutput("bs_wen", 32'(bus_if.bus_wen_o), 32'h0);
        tick();
        checkOutput("bs_ack", 32'(bus_if.data_ack_o), 32'h1);
        bus_if.data_req_i = 1'b0;
        tick();
        checkOutput("bs_ack_pulse", 32'(bus_if.data_ack_o), 32'h0);

        // Misaligned word load
        bus_if.data_req_i  = 1'b1;
        bus_if.data_wen_i  = 1'b1;
        bus_if.data_len_i  = 2'd2;
        bus_if.data_addr_i = 32'h102;
        tick();
        checkOutput("mis_no_bus", 32'(bus_if.bus_req_o), 32'h0);
        tick();
        checkOutput("mis_ack", 32'(bus_if.data_ack_o), 32'h1);
        checkOutput("mis_flag", 32'(bus_if.data_misaligned_o), 32'h1);
        checkOutput("mis_no_bus2", 32'(bus_if.bus_req_o), 32'h0);
        bus_if.data_req_i = 1'b0;
        tick();

        // Three wait states, fetch arrives mid-transaction
        bus_if.data_req_i   = 1'b1;
        bus_if.data_wen_i   = 1'b0;
        bus_if.data_len_i   = 2'd2;
        bus_if.data_addr_i  = 32'h400;
        bus_if.data_wdata_i = 32'h1234_5678;
        bus_if.bus_ack_i    = 1'b0;
        tick();
        bus_if.instr_req_i  = 1'b1;
        bus_if.instr_addr_i = 32'h500;
        for (int c = 1; c <= 4; c++) begin
            checkOutput("ws_req", 32'(bus_if.bus_req_o), 32'h1);
            checkOutput("ws_addr", bus_if.bus_addr_o, 32'h400);
            checkOutput("ws_wmask", 32'(bus_if.bus_wmask_o), 32'hF);
            checkOutput("ws_wdata", bus_if.bus_wdata_o, 32'h1234_5678);
            checkOutput("ws_no_ack", 32'(bus_if.data_ack_o), 32'h0);
            if (c == 4) bus_if.bus_ack_i = 1'b1;
            tick();
        end
        checkOutput("ws_ack", 32'(bus_if.data_ack_o), 32'h1);
        bus_if.data_req_i = 1'b0;
        tick();
        checkOutput("ws_fetch_addr", bus_if.bus_addr_o, 32'h500);
        checkOutput("ws_fetch_wen", 32'(bus_if.bus_wen_o), 32'h1);
        tick();
        checkOutput("ws_fetch_ack", 32'(bus_if.instr_ack_o), 32'h1);
        bus_if.instr_req_i = 1'b0;
        tick();

        // Asynchronous reset while in a data transaction
        bus_if.data_req_i  = 1'b1;
        bus_if.data_wen_i  = 1'b1;
        bus_if.data_len_i  = 2'd2;
        bus_if.data_addr_i = 32'h300;
        bus_if.bus_ack_i   = 1'b0;
        tick();
        checkOutput("ar_pre_req", 32'(bus_if.bus_req_o), 32'h1);
        #2 reset_i = 1'b0;
        #1;
        checkOutput("ar_req_drop", 32'(bus_if.bus_req_o), 32'h0);
        model_reset();
        @(posedge clk_i);
        #1;
        checkOutput("ar_no_ack", 32'(bus_if.data_ack_o), 32'h0);
        reset_i = 1'b1;
        bus_if.bus_ack_i   = 1'b1;
        bus_if.bus_rdata_i = 32'hCAFE_F00D;
        tick();
        tick();
        checkOutput("ar_next_ack", 32'(bus_if.data_ack_o), 32'h1);
        checkOutput("ar_next_rdata", bus_if.data_rdata_o, 32'hCAFE_F00D);
        bus_if.data_req_i = 1'b0;
        tick();

        // Both ports requesting back to back
        hold_both = 1'b1;
        repeat (80) begin
            applyStimulus();
            tick();
        end

        hold_both = 1'b0;
        repeat (1500) begin
            applyStimulus();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
